// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte producers.
// Keeps one frame in flight and aborts if uart_tx never raises busy.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BUSY_TIMEOUT = 4,
  localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      timeout_err,
  output logic [15:0]               sent_count
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_tx_start;
  logic [DATA_W-1:0]  r_tx_data;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_active;
  logic               r_timeout_err;
  logic [15:0]        r_sent_count;

  logic               w_found;
  logic [ID_W-1:0]    w_sel;
  logic [ID_W-1:0]    w_idx;
  logic [DATA_W-1:0]  w_sel_data;
  logic [NUM_REQ-1:0] w_sel_onehot;
  logic               w_grant;
  logic               w_timeout;

  // Search starts just after the last served requester, so it has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_W'((32'(r_ptr) + i) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_data   = '0;
    w_sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_sel == ID_W'(i)) begin
        w_sel_data      = req_data[i*DATA_W +: DATA_W];
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  assign w_grant   = (r_state == S_IDLE) && w_found;
  assign w_timeout = (r_state == S_WAIT_BUSY) && !tx_busy &&
                     (r_cnt == CNT_W'(BUSY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_found) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy)        w_state_nxt = S_WAIT_DONE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so START pulses align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr         <= ID_W'(NUM_REQ - 1);
      r_cnt         <= '0;
      r_ack         <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_active      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_sent_count  <= '0;
    end else begin
      r_tx_start    <= w_grant;
      r_ack         <= w_grant ? w_sel_onehot : '0;
      r_active      <= (w_state_nxt != S_IDLE);
      r_timeout_err <= w_timeout;
      if (w_grant) begin
        r_tx_data  <= w_sel_data;
        r_grant_id <= w_sel;
        r_ptr      <= w_sel;
      end
      if (r_state == S_START)
        r_cnt <= '0;
      else if ((r_state == S_WAIT_BUSY) && !tx_busy && !w_timeout)
        r_cnt <= r_cnt + CNT_W'(1);
      if ((r_state == S_WAIT_DONE) && !tx_busy)
        r_sent_count <= r_sent_count + 16'd1;
    end
  end

  assign ack         = r_ack;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign active      = r_active;
  assign timeout_err = r_timeout_err;
  assign sent_count  = r_sent_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;
  logic [15:0] sent_count;

  typedef struct {
    int         gid;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   exp_sent = 0;
  bit   busy_en = 1'b1;

  uart_tx_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err),
    .sent_count  (sent_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int gid, input logic [7:0] data);
    exp_t e;
    e.gid  = gid;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // uart_tx model: busy rises the cycle after tx_start and lasts 10 cycles.
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1 && busy_en) begin
      @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat (10) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end

  // Monitor: every tx_start pulse is matched against the oldest expected grant.
  initial begin
    exp_t       e;
    logic [3:0] ea;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        check("start_while_busy", 32'(tx_busy), 32'd0);
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_start: grant_id %0d tx_data 0x%0h, expected no frame", grant_id, tx_data);
        end else begin
          e  = sb_q.pop_front();
          ea = 4'b0001 << e.gid;
          check("grant_id", 32'(grant_id), 32'(e.gid));
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("ack", 32'(ack), 32'(ea));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output int t);
    bit seen;
    seen = 1'b0;
    t = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
    end
    check("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (active === 1'b0) break;
    end
    check("return_idle", 32'(active), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_sent_count"}, 32'(sent_count), 32'd0);
  endtask

  task automatic run_frames(input logic [3:0] r, input int n, input bit chk_gap);
    int t;
    int tp;
    tp = 0;
    req = r;
    for (int k = 0; k < n; k++) begin
      wait_start(t);
      if (chk_gap && k > 0) check("start_spacing", 32'(t - tp), 32'd13);
      tp = t;
    end
    tick();
    req = '0;
    wait_idle();
    exp_sent += n;
    check("sent_count", 32'(sent_count), 32'(exp_sent));
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int t;
    int d;
    req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    repeat (2) tick();
    @(negedge clk);
    check_reset("rst");
    reset = 1'b0;

    // Single request from requester 2.
    push(2, 8'hA5);
    req = 4'b0100;
    wait_start(t);
    check("t1_active", 32'(active), 32'd1);
    @(negedge clk);
    check("t1_start_width", 32'(tx_start), 32'd0);
    check("t1_ack_width", 32'(ack), 32'd0);
    req = '0;
    wait_idle();
    check("t1_sent", 32'(sent_count), 32'd1);

    // Round-robin over all four with back-pressure spacing.
    do_reset();
    exp_sent = 0;
    req_data[23:16] = 8'h12;
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
    run_frames(4'b1111, 5, 1'b1);

    // Pointer wrap: after grant 0 -> 3,0; after grant 3 -> 0,3.
    push(3, 8'h13); push(0, 8'h10);
    run_frames(4'b1001, 2, 1'b0);
    push(3, 8'h13);
    run_frames(4'b1000, 1, 1'b0);
    push(0, 8'h10); push(3, 8'h13);
    run_frames(4'b1001, 2, 1'b0);

    // Busy timeout: uart_tx never goes busy.
    busy_en = 1'b0;
    push(1, 8'h11);
    req = 4'b0010;
    wait_start(t);
    req = '0;
    d = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) begin
        d = k;
        break;
      end
    end
    check("t4_timeout_delay", 32'(d), 32'd5);
    check("t4_active", 32'(active), 32'd0);
    check("t4_sent", 32'(sent_count), 32'(exp_sent));
    @(negedge clk);
    check("t4_timeout_width", 32'(timeout_err), 32'd0);
    busy_en = 1'b1;
    push(2, 8'h12);
    run_frames(4'b1111, 1, 1'b0);

    // Reset in the middle of a frame.
    push(2, 8'h12);
    req = 4'b0100;
    wait_start(t);
    repeat (4) @(negedge clk);
    req = '0;
    check("t5_in_wait_done", 32'(tx_busy), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset("t5");
    exp_sent = 0;
    for (int k = 0; k < 20; k++) begin
      if (tx_busy === 1'b0) break;
      @(negedge clk);
    end
    push(0, 8'h10);
    run_frames(4'b1111, 1, 1'b0);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
